// File: rtl/bus_timeout_monitor_pkg.sv
// Shared definitions for the bus timeout monitor: the per-channel FSM
// state encoding, the counter width and the default timeout limits.
package bus_timeout_monitor_pkg;

    localparam int CNT_W            = 8;
    localparam int DEF_UNIBUS_LIMIT = 8;
    localparam int DEF_MEM_LIMIT    = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_EXPIRED = 2'd2
    } to_state_e;

endpackage

// File: rtl/bus_timeout_monitor_to_timer.sv
// One timeout channel. The cycle is pending while req is high and done is
// low. The channel counts consecutive pending cycles. When the count reaches
// LIMIT it emits a single registered pulse, and then stays expired until
// req drops.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   req        : request level (held until completed or abandoned)
//   done       : completion (decode / acknowledge)
//   to_pulse   : one-cycle timeout pulse, in cycle LIMIT of a pending run
module to_timer
    import bus_timeout_monitor_pkg::*;
#(
    parameter int LIMIT = DEF_UNIBUS_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic done,
    output logic to_pulse
);

    if (LIMIT < 2 || LIMIT > 255) begin : g_bad_limit
        $error("to_timer: LIMIT %0d outside legal range 2..255", LIMIT);
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    to_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             pending;

    assign pending = req & ~done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pending) begin
                    state_d = ST_COUNT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_COUNT: begin
                if (!pending) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    // The counter holds at LAST, so it can never wrap.
                    state_d = ST_EXPIRED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EXPIRED: begin
                // A late done does not clear the timeout. Only dropping the
                // request does that.
                if (!req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Pulse only on entry to EXPIRED, never while it is held.
        pulse_d = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign to_pulse = pulse_q;

endmodule

// File: rtl/bus_timeout_monitor.sv
// Bus timeout monitor. It watches CPU iopage cycles and CPU memory cycles
// that are never answered, and reports each with a one-cycle pulse.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   iopage_rd/wr        : iopage strobes (level)
//   iopage_decode       : OR of all iopage device decodes
//   mem_req, mem_ack    : memory request / acknowledge
//   unibus_to           : iopage timeout pulse
//   memory_to           : memory timeout pulse
//   bus_error           : OR of both pulses, to the trap logic
module bus_timeout_monitor
    import bus_timeout_monitor_pkg::*;
#(
    parameter int UNIBUS_LIMIT = DEF_UNIBUS_LIMIT,
    parameter int MEM_LIMIT    = DEF_MEM_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic iopage_rd,
    input  logic iopage_wr,
    input  logic iopage_decode,
    input  logic mem_req,
    input  logic mem_ack,
    output logic unibus_to,
    output logic memory_to,
    output logic bus_error
);

    logic iop_req;
    assign iop_req = iopage_rd | iopage_wr;

    to_timer #(.LIMIT(UNIBUS_LIMIT)) u_unibus (
        .clk      (clk),
        .reset    (reset),
        .req      (iop_req),
        .done     (iopage_decode),
        .to_pulse (unibus_to)
    );

    to_timer #(.LIMIT(MEM_LIMIT)) u_mem (
        .clk      (clk),
        .reset    (reset),
        .req      (mem_req),
        .done     (mem_ack),
        .to_pulse (memory_to)
    );

    // Both inputs are registered pulses. A coincident timeout therefore
    // gives one clean single-cycle pulse.
    assign bus_error = unibus_to | memory_to;

endmodule

// File: tb/tb_bus_timeout_monitor.sv
module tb_bus_timeout_monitor;

    logic clk = 1'b0;
    logic rst, rd, wr, dec, mreq, ack;
    logic a_u, a_m, a_be, b_u, b_m, b_be;

    always #5 clk = ~clk;

    // dut_a: default limits (8 / 64); dut_b: both limits 8
    bus_timeout_monitor dut_a (
        .clk(clk), .reset(rst), .iopage_rd(rd), .iopage_wr(wr),
        .iopage_decode(dec), .mem_req(mreq), .mem_ack(ack),
        .unibus_to(a_u), .memory_to(a_m), .bus_error(a_be)
    );

    bus_timeout_monitor #(.UNIBUS_LIMIT(8), .MEM_LIMIT(8)) dut_b (
        .clk(clk), .reset(rst), .iopage_rd(rd), .iopage_wr(wr),
        .iopage_decode(dec), .mem_req(mreq), .mem_ack(ack),
        .unibus_to(b_u), .memory_to(b_m), .bus_error(b_be)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    // Reference model: run length of consecutive pending cycles, plus a
    // "fired" flag that is held until the request drops.
    // Channels: 0 a-unibus, 1 a-mem, 2 b-unibus, 3 b-mem
    int run_m[4];
    bit fired_m[4];
    int lim_m[4] = '{8, 64, 8, 8};

    function automatic bit model_step(int c, bit r, bit rq, bit dn);
        bit p = 1'b0;
        if (r) begin
            run_m[c] = 0; fired_m[c] = 1'b0;
        end else if (fired_m[c]) begin
            if (!rq) fired_m[c] = 1'b0;
        end else if (rq && !dn) begin
            run_m[c]++;
            if (run_m[c] == lim_m[c]) begin
                p = 1'b1; fired_m[c] = 1'b1; run_m[c] = 0;
            end
        end else begin
            run_m[c] = 0;
        end
        return p;
    endfunction

    logic [5:0] sb_q[$];
    int cyc;
    int pcnt[6];
    int pcyc[6];

    task automatic start_scn();
        cyc = 0;
        for (int i = 0; i < 6; i++) begin pcnt[i] = 0; pcyc[i] = -1; end
    endtask

    // Apply current inputs for one cycle. Push the model's expectation for
    // the following cycle, then pop it and compare against the DUT outputs.
    task automatic tick();
        bit p[4];
        logic [5:0] exp_v, obs;
        for (int c = 0; c < 4; c++) begin
            bit rq, dn;
            rq = (c % 2 == 0) ? (rd | wr) : mreq;
            dn = (c % 2 == 0) ? dec : ack;
            p[c] = model_step(c, rst, rq, dn);
        end
        exp_v = {p[0], p[1], p[0] | p[1], p[2], p[3], p[2] | p[3]};
        sb_q.push_back(exp_v);
        @(posedge clk); #1;
        obs = {a_u, a_m, a_be, b_u, b_m, b_be};
        if (sb_q.size() == 0) chk("sb_empty", 0, 1);
        else chk("sb_outs", int'(obs), int'(sb_q.pop_front()));
        for (int i = 0; i < 6; i++)
            if (obs[5-i]) begin pcnt[i]++; pcyc[i] = cyc + 1; end
        cyc++;
    endtask

    task automatic idle(input int n);
        rst = 0; rd = 0; wr = 0; dec = 0; mreq = 0; ack = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1; rd = 0; wr = 0; dec = 0; mreq = 0; ack = 0;
        start_scn();
        tick(); tick();
        chk("rst_outs", int'({a_u, a_m, a_be, b_u, b_m, b_be}), 0);
        idle(2);

        // Iopage read unanswered for 20 cycles: pulse only in cycle 8
        start_scn();
        rd = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("rd_u_cnt", pcnt[0], 1);
        chk("rd_u_cyc", pcyc[0], 8);
        chk("rd_be_cnt", pcnt[2], 1);
        chk("rd_be_cyc", pcyc[2], 8);
        chk("rd_m_cnt", pcnt[1], 0);
        idle(3);

        // Iopage write, decode at counter = LIMIT-1 cancels the timeout
        start_scn();
        wr = 1;
        for (int i = 0; i < 7; i++) tick();
        dec = 1; tick();
        wr = 0; dec = 0; tick(); tick();
        chk("wr_cancel_cnt", pcnt[0], 0);
        // Repeat with decode one cycle late: pulse in cycle 8
        start_scn();
        wr = 1;
        for (int i = 0; i < 8; i++) tick();
        dec = 1; tick();
        wr = 0; dec = 0; tick(); tick();
        chk("wr_late_cnt", pcnt[0], 1);
        chk("wr_late_cyc", pcyc[0], 8);
        idle(2);

        // mem_req unanswered: pulse at 64, then again 64 after reassert
        start_scn();
        mreq = 1;
        for (int i = 0; i < 100; i++) tick();
        chk("mem1_cnt", pcnt[1], 1);
        chk("mem1_cyc", pcyc[1], 64);
        chk("mem1_u_cnt", pcnt[0], 0);
        mreq = 0; tick();
        mreq = 1;
        for (int i = 0; i < 70; i++) tick();
        chk("mem2_cnt", pcnt[1], 2);
        chk("mem2_cyc", pcyc[1], 165);
        idle(2);

        // Both channels on dut_b with equal limits: one bus_error pulse
        start_scn();
        rd = 1; mreq = 1;
        for (int i = 0; i < 12; i++) tick();
        chk("both_u_cyc", pcyc[3], 8);
        chk("both_m_cyc", pcyc[4], 8);
        chk("both_be_cnt", pcnt[5], 1);
        chk("both_be_cyc", pcyc[5], 8);
        idle(2);

        // Reset during cycle 5 of a held read: fresh count afterwards
        start_scn();
        rd = 1;
        for (int i = 0; i < 5; i++) tick();
        rst = 1; tick();
        rst = 0;
        for (int i = 0; i < 15; i++) tick();
        chk("rst_mid_cnt", pcnt[0], 1);
        chk("rst_mid_cyc", pcyc[0], 14);
        idle(2);

        // Same-cycle ack, 50 times: nothing ever fires
        start_scn();
        for (int i = 0; i < 50; i++) begin
            mreq = 1; ack = 1; tick();
            mreq = 0; ack = 0; tick();
        end
        chk("ack_now_a_cnt", pcnt[1] + pcnt[2], 0);
        chk("ack_now_b_cnt", pcnt[4] + pcnt[5], 0);
        idle(2);

        // Random traffic, checked cycle by cycle through the scoreboard
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 11) == 0) rd = ~rd;
            if ($urandom_range(0, 15) == 0) wr = ~wr;
            if ($urandom_range(0, 11) == 0) mreq = ~mreq;
            dec = ($urandom_range(0, 9) == 0);
            ack = ($urandom_range(0, 9) == 0);
            tick();
        end
        idle(2);
        chk("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_timeout_monitor.md
BUS_TIMEOUT_MONITOR -- requirements
Module: bus_timeout_monitor

Interface
REQ-001 Parameter UNIBUS_LIMIT, default 8: consecutive pending iopage cycles that raise a unibus timeout; legal range 2..255.
REQ-002 Parameter MEM_LIMIT, default 64: consecutive pending memory cycles that raise a memory timeout; legal range 2..255.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iopage_rd  input  1  CPU iopage read strobe; level, held until the cycle completes.
REQ-006 iopage_wr  input  1  CPU iopage write strobe; level, held until the cycle completes.
REQ-007 iopage_decode  input  1  OR of every iopage device decode output.
REQ-008 mem_req  input  1  CPU memory request; level, held until acknowledged or abandoned.
REQ-009 mem_ack  input  1  memory controller acknowledge.
REQ-010 unibus_to  output  1  one-cycle unibus timeout pulse to the CPU error register.
REQ-011 memory_to  output  1  one-cycle memory timeout pulse to the CPU error register.
REQ-012 bus_error  output  1  one-cycle abort pulse to the CPU trap logic; equals unibus_to OR memory_to.

Function
REQ-013 The unibus channel shall treat the cycle as pending when (iopage_rd OR iopage_wr) AND NOT iopage_decode.
REQ-014 The memory channel shall treat the cycle as pending when mem_req AND NOT mem_ack.
REQ-015 Each channel shall run its own FSM with states IDLE, COUNT and EXPIRED, plus an 8-bit counter.
REQ-016 In IDLE, the counter shall be 0; if pending, the next state shall be COUNT with counter 1.
REQ-017 In COUNT, if the channel is not pending, the next state shall be IDLE with counter 0.
REQ-018 In COUNT while pending, if counter equals LIMIT-1, the next state shall be EXPIRED; otherwise the counter shall increment.
REQ-019 The timeout output shall be registered and high for exactly the first cycle in EXPIRED, which is cycle LIMIT counted from the first pending cycle (cycle 0).
REQ-020 EXPIRED shall be left only when the request (strobes or mem_req) deasserts, returning to IDLE; no further pulse is produced while it stays held.
REQ-021 A request whose decode or ack arrives in the same cycle as the request shall never leave IDLE.
REQ-022 A decode or ack arriving in the cycle the counter equals LIMIT-1 shall cancel the timeout: next state IDLE, no pulse.
REQ-023 The two channels shall be fully independent; both pulses may assert in the same cycle, and bus_error is then a single one-cycle pulse.
REQ-024 The counter shall never wrap; it saturates by construction at LIMIT-1.

Reset
REQ-025 While reset is high at a clock edge, both FSMs shall go to IDLE, both counters to 0, and unibus_to, memory_to and bus_error to 0 in the following cycle.
REQ-026 Reset mid-count or in EXPIRED shall discard the pending timeout without any pulse, and a request still held after reset shall start a fresh count from 0.

Structure
REQ-027 The shared package shall hold the IDLE/COUNT/EXPIRED state encoding, the counter width (8), and the default limits 8 and 64.
REQ-028 A sub-module to_timer (inputs req, done; parameter LIMIT; output to_pulse) shall implement one channel and be instantiated twice.
REQ-029 Parameter values outside 2..255 shall produce an elaboration-time error.

Verification
REQ-030 Iopage read held with no decode for 20 cycles -> unibus_to and bus_error high only in cycle 8; memory_to stays 0.
REQ-031 Iopage write with decode in cycle 7 (counter=7=LIMIT-1) -> no pulse, FSM returns to IDLE; a repeat with decode in cycle 8 -> pulse in cycle 8.
REQ-032 mem_req held, no ack, for 100 cycles -> memory_to pulses once, in cycle 64; after mem_req drops and is reasserted, it pulses again 64 cycles later.
REQ-033 Iopage read and mem_req both start in cycle 0, neither answered, with UNIBUS_LIMIT=MEM_LIMIT=8 -> both timeouts and a single bus_error pulse in cycle 8.
REQ-034 Reset asserted in cycle 5 of a pending iopage read, read still held -> no pulse in cycle 8; pulse 8 cycles after reset deasserts.
REQ-035 mem_req with mem_ack in the same cycle, 50 back-to-back times -> FSM stays in IDLE and no outputs ever assert.
